// File: rtl/sound_scheduler.sv
// Purpose : priority scheduler for four fixed tone sequences driving a tone generator.
// Latency : a request is audible 1 cycle after it is sampled; every output is a register (or decodes the state register).
// Backpres: none; requests are one-cycle pulses, lower-priority ones are parked in a non-stacking pending set.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high
//   tick         one-cycle note-step strobe
//   req[3:0]     request pulses: 0 brick bump, 1 explosion, 2 life lost, 3 endgame
//   frequency    tone index for the tone generator
//   enable_sound tone generator audible when 1
//   active_id    sound playing now, or the one that played last
//   busy         state is not IDLE
//   locked       block is muted until reset
module sound_scheduler #(
  parameter int unsigned GAP_TICKS    = 1,  // silent ticks after each sound, 1..7
  parameter int unsigned ENDGAME_LOCK = 1   // 1: finished endgame sound mutes the block
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] req,
  output logic [3:0] frequency,
  output logic       enable_sound,
  output logic [1:0] active_id,
  output logic       busy,
  output logic       locked
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP, LOCKED} state_t;

  state_t     state, state_n;
  logic [3:0] pending, pend_n;
  logic [3:0] remaining, rem_n;
  logic [2:0] gap_cnt, gap_n;
  logic [3:0] freq_n;
  logic       en_n;
  logic [1:0] id_n;

  logic       do_start;
  logic [1:0] start_id;
  logic [1:0] req_id;
  logic [3:0] req_others;
  logic [3:0] merged;

  // Sound table
  function automatic logic [3:0] tbl_start(input logic [1:0] id);
    case (id)
      2'd0:    tbl_start = 4'd0;
      2'd1:    tbl_start = 4'd7;
      2'd2:    tbl_start = 4'd12;
      default: tbl_start = 4'd0;
    endcase
  endfunction

  // Steps are two's complement so a 4-bit add wraps modulo 16.
  function automatic logic [3:0] tbl_step(input logic [1:0] id);
    case (id)
      2'd0:    tbl_step = 4'd2;
      2'd1:    tbl_step = 4'd14;
      2'd2:    tbl_step = 4'd14;
      default: tbl_step = 4'd1;
    endcase
  endfunction

  function automatic logic [3:0] tbl_notes(input logic [1:0] id);
    case (id)
      2'd0:    tbl_notes = 4'd2;
      2'd1:    tbl_notes = 4'd3;
      2'd2:    tbl_notes = 4'd4;
      default: tbl_notes = 4'd9;
    endcase
  endfunction

  function automatic logic [1:0] top_id(input logic [3:0] v);
    if (v[3])      top_id = 2'd3;
    else if (v[2]) top_id = 2'd2;
    else if (v[1]) top_id = 2'd1;
    else           top_id = 2'd0;
  endfunction

  always_comb begin
    state_n    = state;
    pend_n     = pending;
    rem_n      = remaining;
    gap_n      = gap_cnt;
    freq_n     = frequency;
    en_n       = enable_sound;
    id_n       = active_id;
    do_start   = 1'b0;
    start_id   = 2'd0;
    req_id     = top_id(req);
    req_others = req & ~(4'b0001 << req_id);
    merged     = pending | req;

    case (state)
      IDLE: begin
        if (|req) begin
          do_start = 1'b1;
          start_id = req_id;
          pend_n   = pending | req_others;
        end
      end

      PLAY: begin
        if ((|req) && (req_id >= active_id)) begin
          // Preempt or restart; the current sound is dropped and this cycle's tick is lost.
          do_start = 1'b1;
          start_id = req_id;
          pend_n   = pending | req_others;
        end else begin
          pend_n = merged;
          if (tick) begin
            if (remaining > 4'd1) begin
              freq_n = frequency + tbl_step(active_id);
              rem_n  = remaining - 4'd1;
            end else begin
              freq_n = 4'd0;
              en_n   = 1'b0;
              rem_n  = 4'd0;
              if ((active_id == 2'd3) && (ENDGAME_LOCK == 1)) begin
                state_n = LOCKED;
                pend_n  = 4'd0;
              end else begin
                state_n = GAP;
                gap_n   = 3'(GAP_TICKS);
              end
            end
          end
        end
      end

      GAP: begin
        pend_n = merged;
        if (tick) begin
          if (gap_cnt <= 3'd1) begin
            gap_n = 3'd0;
            if (|merged) begin
              do_start = 1'b1;
              start_id = top_id(merged);
              pend_n   = merged & ~(4'b0001 << top_id(merged));
            end else begin
              state_n = IDLE;
            end
          end else begin
            gap_n = gap_cnt - 3'd1;
          end
        end
      end

      default: begin  // LOCKED
        pend_n = 4'd0;
        freq_n = 4'd0;
        en_n   = 1'b0;
      end
    endcase

    if (do_start) begin
      state_n = PLAY;
      freq_n  = tbl_start(start_id);
      rem_n   = tbl_notes(start_id);
      id_n    = start_id;
      en_n    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pending      <= 4'd0;
      remaining    <= 4'd0;
      gap_cnt      <= 3'd0;
      frequency    <= 4'd0;
      enable_sound <= 1'b0;
      active_id    <= 2'd0;
    end else begin
      state        <= state_n;
      pending      <= pend_n;
      remaining    <= rem_n;
      gap_cnt      <= gap_n;
      frequency    <= freq_n;
      enable_sound <= en_n;
      active_id    <= id_n;
    end
  end

  assign busy   = (state != IDLE);
  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_sound_scheduler.sv
// Purpose : directed self-checking bench for sound_scheduler.
// Latency : inputs change 1 ns after a rising edge, outputs are checked 1 ns after the next one.
// Backpres: not applicable.
module tb_sound_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] req;
  logic [3:0] frequency;
  logic       enable_sound;
  logic [1:0] active_id;
  logic       busy;
  logic       locked;

  int checks = 0;
  int errors = 0;

  sound_scheduler #(.GAP_TICKS(1), .ENDGAME_LOCK(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .req          (req),
    .frequency    (frequency),
    .enable_sound (enable_sound),
    .active_id    (active_id),
    .busy         (busy),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given request/tick, then release the pulses.
  task automatic cyc(input logic [3:0] r, input logic t);
    req  = r;
    tick = t;
    @(posedge clk);
    #1;
    req  = 4'd0;
    tick = 1'b0;
  endtask

  // Check the audible outputs in one go.
  task automatic snd(input string tag, input logic en, input logic [3:0] f, input logic [1:0] id);
    chk({tag, ".en"},   16'(enable_sound), 16'(en));
    chk({tag, ".freq"}, 16'(frequency),    16'(f));
    chk({tag, ".id"},   16'(active_id),    16'(id));
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'd0;
    tick  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    snd("reset", 1'b0, 4'd0, 2'd0);
    chk("reset.busy",   16'(busy),          16'd0);
    chk("reset.locked", 16'(locked),        16'd0);
    chk("reset.pend",   16'(dut.pending),   16'd0);
    chk("reset.rem",    16'(dut.remaining), 16'd0);

    // ID0 immediately after reset drops, then gap and back to idle.
    reset = 1'b0;
    cyc(4'b0001, 1'b0);
    snd("id0.n1", 1'b1, 4'd0, 2'd0);
    chk("id0.busy", 16'(busy), 16'd1);
    cyc(4'b0000, 1'b1);
    snd("id0.n2", 1'b1, 4'd2, 2'd0);
    cyc(4'b0000, 1'b1);
    snd("id0.end", 1'b0, 4'd0, 2'd0);
    chk("id0.gap.busy", 16'(busy), 16'd1);
    cyc(4'b0000, 1'b1);
    chk("id0.idle.busy", 16'(busy), 16'd0);
    cyc(4'b0000, 1'b1);
    chk("idle.tick.busy", 16'(busy), 16'd0);
    chk("idle.tick.en",   16'(enable_sound), 16'd0);

    // ID2 with a lower request during note 2, then the queued ID1.
    cyc(4'b0100, 1'b0);
    snd("id2.n1", 1'b1, 4'd12, 2'd2);
    cyc(4'b0000, 1'b1);
    snd("id2.n2", 1'b1, 4'd10, 2'd2);
    cyc(4'b0010, 1'b0);
    chk("id2.pend", 16'(dut.pending), 16'b0010);
    snd("id2.n2b", 1'b1, 4'd10, 2'd2);
    cyc(4'b0000, 1'b1);
    snd("id2.n3", 1'b1, 4'd8, 2'd2);
    cyc(4'b0000, 1'b1);
    snd("id2.n4", 1'b1, 4'd6, 2'd2);
    cyc(4'b0000, 1'b1);
    snd("id2.end", 1'b0, 4'd0, 2'd2);
    cyc(4'b0000, 1'b1);
    snd("id1.n1", 1'b1, 4'd7, 2'd1);
    chk("id1.pend", 16'(dut.pending), 16'd0);
    cyc(4'b0000, 1'b1);
    snd("id1.n2", 1'b1, 4'd5, 2'd1);
    cyc(4'b0000, 1'b1);
    snd("id1.n3", 1'b1, 4'd3, 2'd1);
    cyc(4'b0000, 1'b1);
    snd("id1.end", 1'b0, 4'd0, 2'd1);
    cyc(4'b0000, 1'b1);
    chk("id1.idle.busy", 16'(busy), 16'd0);

    // Endgame preempts ID1, steps 0..8, then locks.
    cyc(4'b0010, 1'b0);
    snd("pre.n1", 1'b1, 4'd7, 2'd1);
    cyc(4'b0000, 1'b1);
    snd("pre.n2", 1'b1, 4'd5, 2'd1);
    cyc(4'b1000, 1'b0);
    snd("id3.n1", 1'b1, 4'd0, 2'd3);
    chk("id3.rem", 16'(dut.remaining), 16'd9);
    for (int i = 1; i <= 8; i++) begin
      cyc(4'b0000, 1'b1);
      snd($sformatf("id3.n%0d", i + 1), 1'b1, 4'(i), 2'd3);
    end
    cyc(4'b0000, 1'b1);
    snd("lock", 1'b0, 4'd0, 2'd3);
    chk("lock.locked", 16'(locked),      16'd1);
    chk("lock.pend",   16'(dut.pending), 16'd0);
    cyc(4'b0111, 1'b1);
    snd("lock.req", 1'b0, 4'd0, 2'd3);
    chk("lock.req.locked", 16'(locked),      16'd1);
    chk("lock.req.pend",   16'(dut.pending), 16'd0);
    reset = 1'b1;
    cyc(4'b0000, 1'b0);
    chk("unlock.locked", 16'(locked), 16'd0);
    chk("unlock.busy",   16'(busy),   16'd0);
    reset = 1'b0;

    // Three simultaneous requests play ID2, ID1, ID0 with 1-tick gaps.
    cyc(4'b0111, 1'b0);
    snd("multi.id2", 1'b1, 4'd12, 2'd2);
    chk("multi.pend", 16'(dut.pending), 16'b0011);
    cyc(4'b0000, 1'b1); snd("multi.id2.n2", 1'b1, 4'd10, 2'd2);
    cyc(4'b0000, 1'b1); snd("multi.id2.n3", 1'b1, 4'd8, 2'd2);
    cyc(4'b0000, 1'b1); snd("multi.id2.n4", 1'b1, 4'd6, 2'd2);
    cyc(4'b0000, 1'b1); snd("multi.gap1", 1'b0, 4'd0, 2'd2);
    cyc(4'b0000, 1'b1); snd("multi.id1", 1'b1, 4'd7, 2'd1);
    chk("multi.pend2", 16'(dut.pending), 16'b0001);
    cyc(4'b0000, 1'b1); snd("multi.id1.n2", 1'b1, 4'd5, 2'd1);
    cyc(4'b0000, 1'b1); snd("multi.id1.n3", 1'b1, 4'd3, 2'd1);
    cyc(4'b0000, 1'b1); snd("multi.gap2", 1'b0, 4'd0, 2'd1);
    cyc(4'b0000, 1'b1); snd("multi.id0", 1'b1, 4'd0, 2'd0);
    chk("multi.pend3", 16'(dut.pending), 16'd0);
    cyc(4'b0000, 1'b1); snd("multi.id0.n2", 1'b1, 4'd2, 2'd0);
    cyc(4'b0000, 1'b1); snd("multi.gap3", 1'b0, 4'd0, 2'd0);
    cyc(4'b0000, 1'b1);
    chk("multi.idle", 16'(busy), 16'd0);

    // Reset in the middle of the endgame sound.
    cyc(4'b1000, 1'b0);
    for (int i = 1; i <= 5; i++) cyc(4'b0000, 1'b1);
    snd("mid.id3", 1'b1, 4'd5, 2'd3);
    reset = 1'b1;
    cyc(4'b0000, 1'b0);
    snd("mid.rst", 1'b0, 4'd0, 2'd0);
    chk("mid.rst.busy", 16'(busy),          16'd0);
    chk("mid.rst.lock", 16'(locked),        16'd0);
    chk("mid.rst.rem",  16'(dut.remaining), 16'd0);
    reset = 1'b0;
    cyc(4'b0001, 1'b0); snd("post.id0", 1'b1, 4'd0, 2'd0);
    cyc(4'b0000, 1'b1); snd("post.n2",  1'b1, 4'd2, 2'd0);
    cyc(4'b0000, 1'b1); snd("post.end", 1'b0, 4'd0, 2'd0);
    cyc(4'b0000, 1'b1);
    chk("post.idle", 16'(busy), 16'd0);

    // Same-ID restart on note 3 with a coincident tick.
    cyc(4'b0100, 1'b0);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    snd("rs.n3", 1'b1, 4'd8, 2'd2);
    cyc(4'b0100, 1'b1);
    snd("rs.restart", 1'b1, 4'd12, 2'd2);
    chk("rs.rem", 16'(dut.remaining), 16'd4);
    cyc(4'b0000, 1'b1);
    snd("rs.n2", 1'b1, 4'd10, 2'd2);
    chk("rs.rem2", 16'(dut.remaining), 16'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
